can_destuffer_fd: RTL and testbench

CAN_DESTUFFER_FD -- requirements
Module: can_destuffer_fd

---
 rtl/can_destuffer_fd.sv | 162 ++++++++++++++++
 tb/tb_can_destuffer_fd.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_destuffer_fd.sv
// CAN / CAN FD receive bit destuffer: removes dynamic stuff bits (run-length rule)
// and fixed stuff bits (FD stuff-count / CRC fields), flagging stuff-rule violations.
module can_destuffer_fd #(
    parameter int STUFF_LEN = 5,
    parameter int FIXED_LEN = 4,
    parameter int CNT_W     = 3
) (
    input  logic             Clock_SP,
    input  logic             Reset,
    input  logic             Bit_Valid,
    input  logic             Bit_Input,
    input  logic             Frame_Start,
    input  logic             Stuff_Enable,
    input  logic             Fixed_Mode,
    output logic             Data_Valid,
    output logic             Data_Bit,
    output logic             Ignora_Bit,
    output logic             Error_Stuffing,
    output logic [CNT_W-1:0] Stuff_Count
);

    localparam int RUN_W = $clog2(STUFF_LEN + 1);
    localparam int FIX_W = $clog2(FIXED_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_LEN);
    localparam logic [FIX_W-1:0] FIX_MAX = FIX_W'(FIXED_LEN);

    typedef enum logic [1:0] {ST_IDLE, ST_DYN, ST_FIXED, ST_ERR} state_t;
    typedef enum logic [2:0] {
        EV_NONE, EV_SOF, EV_PASS, EV_DATA, EV_DSTUFF, EV_FDATA, EV_FSTUFF, EV_ERR
    } event_t;

    state_t           r_state;
    logic [RUN_W-1:0] r_run;
    logic [FIX_W-1:0] r_fix;
    logic             r_last;
    logic [CNT_W-1:0] r_stuff_cnt;
    logic             r_data_valid;
    logic             r_data_bit;
    logic             r_ignora;
    logic             r_err;

    event_t           w_ev;
    state_t           w_state_nxt;
    logic [RUN_W-1:0] w_run_nxt;
    logic [FIX_W-1:0] w_fix_nxt;
    logic             w_last_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_dv_nxt;
    logic             w_ign_nxt;
    logic             w_err_nxt;
    logic             w_differs;

    assign w_differs = (Bit_Input != r_last);

    // Classify the current valid bit; Frame_Start overrides every stuff rule.
    always_comb begin
        w_ev = EV_NONE;
        if (Bit_Valid) begin
            if (Frame_Start) begin
                w_ev = EV_SOF;
            end else begin
                case (r_state)
                    ST_IDLE: w_ev = EV_PASS;
                    ST_DYN: begin
                        if (!Stuff_Enable)           w_ev = EV_PASS;
                        else if (Fixed_Mode)         w_ev = w_differs ? EV_FSTUFF : EV_ERR;
                        else if (r_run < RUN_MAX)    w_ev = EV_DATA;
                        else                         w_ev = w_differs ? EV_DSTUFF : EV_ERR;
                    end
                    ST_FIXED: begin
                        if (!Stuff_Enable)           w_ev = EV_PASS;
                        else if (r_fix < FIX_MAX)    w_ev = EV_FDATA;
                        else                         w_ev = w_differs ? EV_FSTUFF : EV_ERR;
                    end
                    default: w_ev = EV_NONE;
                endcase
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_fix_nxt   = r_fix;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_stuff_cnt;
        case (w_ev)
            EV_SOF: begin
                w_state_nxt = ST_DYN;
                w_run_nxt   = RUN_W'(1);
                w_last_nxt  = Bit_Input;
                w_cnt_nxt   = '0;
            end
            EV_PASS: w_state_nxt = ST_IDLE;
            EV_DATA: begin
                w_run_nxt  = w_differs ? RUN_W'(1) : r_run + RUN_W'(1);
                w_last_nxt = Bit_Input;
            end
            EV_DSTUFF: begin
                // The stuff bit opens the next run.
                w_run_nxt  = RUN_W'(1);
                w_last_nxt = Bit_Input;
                w_cnt_nxt  = r_stuff_cnt + CNT_W'(1);
            end
            EV_FDATA: begin
                w_fix_nxt  = r_fix + FIX_W'(1);
                w_last_nxt = Bit_Input;
            end
            EV_FSTUFF: begin
                w_state_nxt = ST_FIXED;
                w_fix_nxt   = '0;
                w_last_nxt  = Bit_Input;
            end
            EV_ERR:  w_state_nxt = ST_ERR;
            default: w_state_nxt = r_state;
        endcase
    end

    always_comb begin
        w_dv_nxt  = (w_ev == EV_SOF) || (w_ev == EV_PASS) ||
                    (w_ev == EV_DATA) || (w_ev == EV_FDATA);
        w_ign_nxt = (w_ev == EV_DSTUFF) || (w_ev == EV_FSTUFF);
        w_err_nxt = (w_ev == EV_ERR);
    end

    always_ff @(posedge Clock_SP or posedge Reset) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_run       <= '0;
            r_fix       <= '0;
            r_last      <= 1'b1;
            r_stuff_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_run       <= w_run_nxt;
            r_fix       <= w_fix_nxt;
            r_last      <= w_last_nxt;
            r_stuff_cnt <= w_cnt_nxt;
        end
    end

    always_ff @(posedge Clock_SP or posedge Reset) begin
        if (Reset) begin
            r_data_valid <= 1'b0;
            r_data_bit   <= 1'b0;
            r_ignora     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_data_valid <= w_dv_nxt;
            r_ignora     <= w_ign_nxt;
            r_err        <= w_err_nxt;
            if (Bit_Valid) r_data_bit <= Bit_Input;
        end
    end

    assign Data_Valid     = r_data_valid;
    assign Data_Bit       = r_data_bit;
    assign Ignora_Bit     = r_ignora;
    assign Error_Stuffing = r_err;
    assign Stuff_Count    = r_stuff_cnt;

endmodule

// File: tb/tb_can_destuffer_fd.sv
// Testbench for can_destuffer_fd: directed frame scenarios plus randomized traffic
// checked against a run-queue based reference model of the stuffing rules.
module tb_can_destuffer_fd;

    localparam int STUFF_LEN = 5;
    localparam int FIXED_LEN = 4;
    localparam int CNT_W     = 3;

    logic             Clock_SP;
    logic             Reset;
    logic             Bit_Valid;
    logic             Bit_Input;
    logic             Frame_Start;
    logic             Stuff_Enable;
    logic             Fixed_Mode;
    logic             Data_Valid;
    logic             Data_Bit;
    logic             Ignora_Bit;
    logic             Error_Stuffing;
    logic [CNT_W-1:0] Stuff_Count;

    int n_tests = 0;
    int n_fail  = 0;

    can_destuffer_fd #(.STUFF_LEN(STUFF_LEN), .FIXED_LEN(FIXED_LEN), .CNT_W(CNT_W)) dut (
        .Clock_SP      (Clock_SP),
        .Reset         (Reset),
        .Bit_Valid     (Bit_Valid),
        .Bit_Input     (Bit_Input),
        .Frame_Start   (Frame_Start),
        .Stuff_Enable  (Stuff_Enable),
        .Fixed_Mode    (Fixed_Mode),
        .Data_Valid    (Data_Valid),
        .Data_Bit      (Data_Bit),
        .Ignora_Bit    (Ignora_Bit),
        .Error_Stuffing(Error_Stuffing),
        .Stuff_Count   (Stuff_Count)
    );

    initial begin
        Clock_SP = 1'b0;
        forever #5 Clock_SP = ~Clock_SP;
    end

    // Reference model: the current run of equal bits is held as a queue; its
    // size is the run length and its tail is the previous bit.
    typedef enum int {M_IDLE, M_DYN, M_FIXED, M_ERR} mmode_t;
    mmode_t m_mode = M_IDLE;
    bit     m_run_q[$];
    bit     m_last = 1'b1;
    int     m_fix  = 0;
    int     m_cnt  = 0;
    bit     e_dv = 1'b0, e_ign = 1'b0, e_err = 1'b0, e_db = 1'b0;

    task automatic model_reset();
        m_mode = M_IDLE;
        m_run_q.delete();
        m_last = 1'b1;
        m_fix  = 0;
        m_cnt  = 0;
        e_dv = 1'b0; e_ign = 1'b0; e_err = 1'b0; e_db = 1'b0;
    endtask

    task automatic model_fixed_stuff(input bit b);
        if (b != m_last) begin
            e_ign  = 1'b1;
            m_fix  = 0;
            m_last = b;
        end else begin
            e_err  = 1'b1;
            m_mode = M_ERR;
        end
    endtask

    task automatic model_edge(input bit v, input bit b, input bit sof, input bit se, input bit fm);
        e_dv = 1'b0; e_ign = 1'b0; e_err = 1'b0;
        if (!v) return;
        e_db = b;
        if (sof) begin
            m_mode = M_DYN;
            m_run_q.delete();
            m_run_q.push_back(b);
            m_last = b;
            m_cnt  = 0;
            e_dv   = 1'b1;
            return;
        end
        if (m_mode == M_ERR) return;
        if ((m_mode == M_DYN || m_mode == M_FIXED) && !se) m_mode = M_IDLE;
        if (m_mode == M_IDLE) begin
            e_dv = 1'b1;
            return;
        end
        if (m_mode == M_DYN && fm) begin
            m_mode = M_FIXED;
            model_fixed_stuff(b);
            return;
        end
        if (m_mode == M_FIXED) begin
            if (m_fix < FIXED_LEN) begin
                e_dv   = 1'b1;
                m_fix  = m_fix + 1;
                m_last = b;
            end else begin
                model_fixed_stuff(b);
            end
            return;
        end
        if (m_run_q.size() < STUFF_LEN) begin
            e_dv = 1'b1;
            if (b != m_last) m_run_q.delete();
            m_run_q.push_back(b);
            m_last = b;
        end else if (b != m_last) begin
            e_ign = 1'b1;
            m_run_q.delete();
            m_run_q.push_back(b);
            m_last = b;
            m_cnt  = (m_cnt + 1) % (1 << CNT_W);
        end else begin
            e_err  = 1'b1;
            m_mode = M_ERR;
        end
    endtask

    // Apply one bit slot, advance the model, and leave time 1 unit past the edge.
    task automatic drive(input logic v, input logic b, input logic sof, input logic se, input logic fm);
        Bit_Valid    = v;
        Bit_Input    = b;
        Frame_Start  = sof;
        Stuff_Enable = se;
        Fixed_Mode   = fm;
        @(posedge Clock_SP);
        if (Reset) model_reset();
        else       model_edge(v, b, sof, se, fm);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            got = {Data_Valid, Ignora_Bit, Error_Stuffing, Data_Bit, 1'b0, Stuff_Count};
            n_tests++;
            if (got !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: outputs got %b expected %b", i, got, 8'h00);
            end
        end
        Reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        got = {Data_Valid, Ignora_Bit, Error_Stuffing, Data_Bit, 1'b0, Stuff_Count};
        n_tests++;
        if (got !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_release: outputs got %b expected %b", got, 8'h00);
        end
    endtask

    task automatic test_dynamic_stuff();
        logic [10:0] bits = 11'b00000111110;
        logic [10:0] ign  = 11'b00000100001;
        logic [2:0]  got, exp;
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, bits[10-i], (i == 0), 1'b1, 1'b0);
            got = {Data_Valid, Ignora_Bit, Error_Stuffing};
            exp = ign[10-i] ? 3'b010 : 3'b100;
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL dyn_stuff bit %0d: pulses got %b expected %b", i + 1, got, exp);
            end
            n_tests++;
            if (Data_Bit !== bits[10-i]) begin
                n_fail++;
                $display("FAIL dyn_data_bit bit %0d: got %b expected %b", i + 1, Data_Bit, bits[10-i]);
            end
        end
        n_tests++;
        if (Stuff_Count !== CNT_W'(2)) begin
            n_fail++;
            $display("FAIL dyn_stuff_count: got %0d expected 2", Stuff_Count);
        end
    endtask

    task automatic test_stuff_error();
        logic [10:0] bits = 11'b00000010111;
        logic [10:0] sof  = 11'b10000000001;
        logic [2:0]  exp [11] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001,
                                  3'b000, 3'b000, 3'b000, 3'b000, 3'b100};
        logic [2:0]  got;
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, bits[10-i], sof[10-i], 1'b1, 1'b0);
            got = {Data_Valid, Ignora_Bit, Error_Stuffing};
            n_tests++;
            if (got !== exp[i]) begin
                n_fail++;
                $display("FAIL stuff_error bit %0d: pulses got %b expected %b", i + 1, got, exp[i]);
            end
        end
    endtask

    task automatic test_fixed_mode();
        logic [7:0] bits = 8'b10101110;
        logic [7:0] fm   = 8'b01111111;
        logic [2:0] exp [8] = '{3'b100, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b000};
        logic [2:0] got;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, bits[7-i], (i == 0), 1'b1, fm[7-i]);
            got = {Data_Valid, Ignora_Bit, Error_Stuffing};
            n_tests++;
            if (got !== exp[i]) begin
                n_fail++;
                $display("FAIL fixed_mode bit %0d: pulses got %b expected %b", i + 1, got, exp[i]);
            end
        end
        n_tests++;
        if (Stuff_Count !== CNT_W'(0)) begin
            n_fail++;
            $display("FAIL fixed_stuff_count: got %0d expected 0", Stuff_Count);
        end
    endtask

    task automatic test_stuff_disabled();
        logic [2:0] got;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, (i == 0), (i == 0), 1'b0, 1'b0);
            got = {Data_Valid, Ignora_Bit, Error_Stuffing};
            n_tests++;
            if (got !== 3'b100) begin
                n_fail++;
                $display("FAIL stuff_disabled bit %0d: pulses got %b expected %b", i, got, 3'b100);
            end
        end
    endtask

    task automatic test_valid_gap();
        logic [8:0] vld  = 9'b110001111;
        logic [8:0] bits = 9'b001110001;
        logic [2:0] exp [9] = '{3'b100, 3'b100, 3'b000, 3'b000, 3'b000,
                                3'b100, 3'b100, 3'b100, 3'b010};
        logic [2:0] got;
        for (int i = 0; i < 9; i++) begin
            drive(vld[8-i], bits[8-i], (i == 0), 1'b1, 1'b0);
            got = {Data_Valid, Ignora_Bit, Error_Stuffing};
            n_tests++;
            if (got !== exp[i]) begin
                n_fail++;
                $display("FAIL valid_gap slot %0d: pulses got %b expected %b", i, got, exp[i]);
            end
        end
        n_tests++;
        if (Stuff_Count !== CNT_W'(1)) begin
            n_fail++;
            $display("FAIL gap_stuff_count: got %0d expected 1", Stuff_Count);
        end
    endtask

    task automatic test_reset_midrun();
        logic [7:0] got;
        logic [2:0] pul;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, (i == 0), 1'b1, 1'b0);
        Reset = 1'b1;
        model_reset();
        #1;
        got = {Data_Valid, Ignora_Bit, Error_Stuffing, Data_Bit, 1'b0, Stuff_Count};
        n_tests++;
        if (got !== 8'h00) begin
            n_fail++;
            $display("FAIL midrun_async_reset: outputs got %b expected %b", got, 8'h00);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            got = {Data_Valid, Ignora_Bit, Error_Stuffing, Data_Bit, 1'b0, Stuff_Count};
            n_tests++;
            if (got !== 8'h00) begin
                n_fail++;
                $display("FAIL midrun_reset_hold cycle %0d: outputs got %b expected %b", i, got, 8'h00);
            end
        end
        Reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        pul = {Data_Valid, Ignora_Bit, Error_Stuffing};
        n_tests++;
        if (pul !== 3'b000) begin
            n_fail++;
            $display("FAIL midrun_release: pulses got %b expected %b", pul, 3'b000);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            pul = {Data_Valid, Ignora_Bit, Error_Stuffing};
            n_tests++;
            if (pul !== 3'b100) begin
                n_fail++;
                $display("FAIL midrun_idle bit %0d: pulses got %b expected %b", i, pul, 3'b100);
            end
        end
    endtask

    task automatic test_random();
        logic       se = 1'b1, fm = 1'b0, b = 1'b0, v, sof;
        logic [6:0] got, exp;
        for (int i = 0; i < 600; i++) begin
            sof = ($urandom_range(0, 39) == 0);
            if (sof) begin
                se = 1'b1;
                fm = 1'b0;
            end else begin
                if ($urandom_range(0, 24) == 0) se = ~se;
                if ($urandom_range(0, 11) == 0) fm = ~fm;
            end
            v = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 3) == 0) b = ~b;
            drive(v, b, sof, se, fm);
            got = {Data_Valid, Ignora_Bit, Error_Stuffing, Data_Bit, Stuff_Count};
            exp = {e_dv, e_ign, e_err, e_db, CNT_W'(m_cnt)};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random step %0d: {dv,ign,err,bit,cnt} got %b expected %b", i, got, exp);
            end
        end
    endtask

    initial begin
        Reset        = 1'b1;
        Bit_Valid    = 1'b0;
        Bit_Input    = 1'b1;
        Frame_Start  = 1'b0;
        Stuff_Enable = 1'b0;
        Fixed_Mode   = 1'b0;
        test_reset();
        test_dynamic_stuff();
        test_stuff_error();
        test_fixed_mode();
        test_stuff_disabled();
        test_valid_gap();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
